// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Sequencing front-end for a 3-bit-opcode combinational ALU. It holds a small
// operand register file and accepts register-addressed commands on a
// valid/ready handshake. It presents the operands to the ALU and captures the
// result and flags one cycle later. It then writes the result back and returns
// a response on a second valid/ready handshake.
//
// Optional feature: define ALU_STICKY_OF_EN to enable the sticky overflow
// flag. If it is undefined, sticky_of is tied low and clr_sticky is ignored.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ld_en/addr/data     direct register load, honoured in any state
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op/ra/rb/rd     opcode, source registers, destination register
//   A, B, ALU_OP        operands and opcode driven to the ALU
//   F, ZF, OF           ALU result and flags
//   res_valid/ready     response handshake (valid only while responding)
//   res_data/zf/of/rd   captured result, flags and destination
//   sticky_of           overflow seen since last clear (optional)
//   clr_sticky          clears sticky_of
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int WIDTH = 32,
   parameter int RAW   = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_en,
   input  logic [RAW-1:0]   ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [RAW-1:0]   cmd_ra,
   input  logic [RAW-1:0]   cmd_rb,
   input  logic [RAW-1:0]   cmd_rd,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [2:0]       ALU_OP,
   input  logic [WIDTH-1:0] F,
   input  logic             ZF,
   input  logic             OF,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zf,
   output logic             res_of,
   output logic [RAW-1:0]   res_rd,
   output logic             sticky_of,
   input  logic             clr_sticky
);

   localparam int NREG = 2 ** RAW;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] rf_d [NREG];
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [RAW-1:0]   rd_q, rd_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_zf_q, res_zf_d;
   logic             res_of_q, res_of_d;
   logic [RAW-1:0]   res_rd_q, res_rd_d;
   logic             sticky_q, sticky_d;

   // r0 is never written, so it stays at its reset value of zero. Reads of r0
   // therefore need no special case.
   always_comb begin
      // NOTE: every signal gets a default before any branch. Otherwise a path
      // that skips the assignment infers a latch.
      state_d    = state_q;
      rf_d       = rf_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      rd_d       = rd_q;
      res_data_d = res_data_q;
      res_zf_d   = res_zf_q;
      res_of_d   = res_of_q;
      res_rd_d   = res_rd_q;

      if (ld_en && (ld_addr != '0)) begin
         rf_d[ld_addr] = ld_data;
      end

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               // Sources are read from rf_q, the pre-edge contents. A load
               // on the same edge is not seen by this command.
               a_d     = rf_q[cmd_ra];
               b_d     = rf_q[cmd_rb];
               op_d    = cmd_op;
               rd_d    = cmd_rd;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            res_data_d = F;
            res_zf_d   = ZF;
            res_of_d   = OF;
            res_rd_d   = rd_q;
            // This write comes after the ld_en write, so writeback wins on
            // an address collision.
            if (rd_q != '0) begin
               rf_d[rd_q] = F;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef ALU_STICKY_OF_EN
   // Set is applied after clear, so set wins when both happen on one edge.
   always_comb begin
      sticky_d = sticky_q;
      if (clr_sticky) begin
         sticky_d = 1'b0;
      end
      if ((state_q == S_EXEC) && OF) begin
         sticky_d = 1'b1;
      end
   end
`else
   logic unused_clr_sticky;
   assign unused_clr_sticky = clr_sticky;
   assign sticky_d          = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only. All flops
   // then update together and never race each other.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         rd_q       <= '0;
         res_data_q <= '0;
         res_zf_q   <= 1'b0;
         res_of_q   <= 1'b0;
         res_rd_q   <= '0;
         sticky_q   <= 1'b0;
         // NOTE: the register file is reset as well. Software expects
         // zeroed operands, and r0 depends on it to read as zero.
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         res_data_q <= res_data_d;
         res_zf_q   <= res_zf_d;
         res_of_q   <= res_of_d;
         res_rd_q   <= res_rd_d;
         sticky_q   <= sticky_d;
         rf_q       <= rf_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign res_valid = (state_q == S_RESP);
   assign A         = a_q;
   assign B         = b_q;
   assign ALU_OP    = op_q;
   assign res_data  = res_data_q;
   assign res_zf    = res_zf_q;
   assign res_of    = res_of_q;
   assign res_rd    = res_rd_q;
   assign sticky_of = sticky_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing front-end that drives the 3-bit-opcode combinational ALU (A/B/ALU_OP in, F/ZF/OF out).
- Holds a small operand register file and accepts register-addressed commands over a valid/ready handshake.
- Presents operands to the ALU, captures result and flags, writes back, and returns a response over a second valid/ready handshake.
- Sits between the lab datapath test harness and the ALU instance.

Parameters:
- WIDTH, 32, datapath width (ALU operand/result width)
- RAW, 3, register-file address width (2**RAW registers; r0 reads as zero)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- ld_en  input  1  register load strobe, honoured in any state
- ld_addr  input  RAW  register to load
- ld_data  input  WIDTH  load value
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_op  input  3  ALU opcode
- cmd_ra  input  RAW  operand A register
- cmd_rb  input  RAW  operand B register
- cmd_rd  input  RAW  destination register
- A  output  WIDTH  to ALU operand A
- B  output  WIDTH  to ALU operand B
- ALU_OP  output  3  to ALU opcode
- F  input  WIDTH  ALU result
- ZF  input  1  ALU zero flag
- OF  input  1  ALU overflow flag
- res_valid  output  1  response present
- res_ready  input  1  response consumed
- res_data  output  WIDTH  captured result
- res_zf  output  1  captured ZF
- res_of  output  1  captured OF
- res_rd  output  RAW  destination of this response
- sticky_of  output  1  sticky overflow status (see Optional Feature)
- clr_sticky  input  1  clears sticky_of

Behaviour:
- Reset (async, rst=1): FSM=IDLE, A=B=0, ALU_OP=000, res_* =0, res_valid=0, sticky_of=0, all registers=0. Reset mid-command aborts it: no writeback, no response.
- FSM states: IDLE, EXEC, RESP. cmd_ready=1 only in IDLE; res_valid=1 only in RESP.
- IDLE: on cmd_valid&cmd_ready edge, register A<=RF[cmd_ra], B<=RF[cmd_rb], ALU_OP<=cmd_op, latch cmd_rd; go to EXEC.
- EXEC (one cycle, ALU settles combinationally): at the edge, capture res_data<=F, res_zf<=ZF, res_of<=OF, res_rd<=rd. Write RF[rd]<=F unless rd==0. Go to RESP.
- RESP: hold all res_* stable while res_ready=0. On res_valid&res_ready edge go to IDLE.
- A/B/ALU_OP hold their last values outside EXEC.
- Timing: min command-to-response latency is 2 edges after accept; min throughput is 1 command per 3 cycles.
- Register file reads sample the pre-edge contents, so a same-edge ld_en to a source register is not seen by the current command.
- ld_en and EXEC writeback to the same address on the same edge: writeback wins. Different addresses: both write.
- ld_addr==0 or rd==0: write ignored; r0 always reads 0.
- Opcode passes through unmodified; all 8 codes are legal; no arithmetic in this block.

Optional Feature:
- Macro ALU_STICKY_OF_EN.
- Defined: sticky_of is set at any EXEC capture with OF=1. It is cleared on the next edge when clr_sticky=1. If set and clear coincide, set wins.
- Undefined: sticky_of tied 0 and clr_sticky ignored; port list unchanged.

Test Plan:
- Load r1=5, r2=3; cmd op=100 ra=1 rb=2 rd=3 -> res_data=8, res_zf=0, res_rd=3; a follow-up op=000 ra=3 rb=3 rd=4 returns 8.
- Load r1=r2=0x1234; op=101 rd=5 -> res_data=0, res_zf=1; r5 reads 0.
- Load r1=4, r2=1; op=111 ra=1 rb=2 -> res_data=16. Repeat with rd=0 -> response 16 but r0 stays 0.
- Load r1=0x7FFFFFFF, r2=1; op=100 -> res_of=1. With ALU_STICKY_OF_EN, sticky_of=1 until clr_sticky; without it, sticky_of=0.
- Hold res_ready=0 for 5 cycles in RESP -> res_* stable, cmd_ready=0, second cmd_valid not accepted until handshake.
- Assert rst during EXEC -> all outputs 0 immediately, no writeback to rd, cmd_ready=1 after release.
